opb_register_bank_ppc2simulink: RTL and testbench

Parametrised bank of C_NUM_REGS 32-bit software registers written and read by the PowerPC over OPB, with outputs to the Simulink user fabric.
- Optional double-buffered mode: writes land in shadow registers and reach the user outputs together on a commit, so multi-word settings (e.g. ADC delay tap sets) apply in the same cycle.
- Single clock domain: the user logic runs on OPB_Clk, so there are no clock-domain crossings.

---
 rtl/opb_register_bank_ppc2simulink.sv | 159 +++++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: C_NUM_REGS software registers plus one control
// register, driving the Simulink user fabric on the same clock. Optional
// shadow/commit mode so multi-word settings reach the fabric in one cycle.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01001000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010010FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter int          C_DOUBLE_BUF = 0,
  parameter logic [31:0] C_INIT       = 32'h00000000,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]      OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]    OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]      OPB_DBus,
  input  logic                         OPB_RNW,
  input  logic                         OPB_select,
  input  logic                         OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]      Sl_DBus,
  output logic                         Sl_xferAck,
  output logic                         Sl_errAck,
  output logic                         Sl_retry,
  output logic                         Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]     user_data_out,
  output logic [C_NUM_REGS-1:0]        user_update,
  output logic [15:0]                  commit_count
);

  localparam logic [0:0]  S_IDLE   = 1'b0;
  localparam logic [0:0]  S_ACK    = 1'b1;
  localparam logic [29:0] CTRL_IDX = 30'(C_NUM_REGS);
  localparam bit          DBUF     = (C_DOUBLE_BUF != 0);

  logic [0:0]                   state_q, state_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic [C_NUM_REGS-1:0][31:0]  shadow_q, shadow_d;
  logic [C_NUM_REGS-1:0][31:0]  out_q, out_d;
  logic [C_NUM_REGS-1:0]        upd_q, upd_d;
  logic [15:0]                  commit_q, commit_d;
  logic                         pend_q, pend_d;

  // Bus fields in numeric (MSB-left) order: DBus[0] lands on bit 31,
  // BE[0] lands on be[3] and therefore governs bits 31:24.
  logic [31:0] addr, wdata, offs, rd_mux;
  logic [3:0]  be;
  logic [29:0] widx;
  logic        hit, is_ctrl, unused_ok;
  logic [C_NUM_REGS-1:0] sel;

  assign addr    = OPB_ABus;
  assign wdata   = OPB_DBus;
  assign be      = OPB_BE;
  assign offs    = addr - C_BASEADDR;
  assign widx    = offs[31:2];
  assign hit     = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign is_ctrl = (widx == CTRL_IDX);

  assign unused_ok = ^{OPB_seqAddr, offs[1:0], C_FAMILY};

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_sel
      assign sel[gi] = (widx == 30'(gi));
    end
  endgenerate

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  b);
    be_merge = old_v;
    for (int k = 0; k < 4; k++)
      if (b[k]) be_merge[8*k +: 8] = new_v[8*k +: 8];
  endfunction

  // Read data mux: shadow for data words, status for control, 0 for holes.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < C_NUM_REGS; i++)
      if (sel[i]) rd_mux = shadow_q[i];
    if (is_ctrl) rd_mux = {15'd0, pend_q, commit_q};
  end

  // Transfer FSM and register next-state.
  always_comb begin
    state_d  = state_q;
    rdata_d  = '0;
    shadow_d = shadow_q;
    out_d    = out_q;
    upd_d    = '0;
    commit_d = commit_q;
    pend_d   = pend_q;
    case (state_q)
      S_IDLE: begin
        if (OPB_select && hit) begin
          state_d = S_ACK;
          if (OPB_RNW) begin
            rdata_d = rd_mux;
          end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
              if (sel[i]) begin
                shadow_d[i] = be_merge(shadow_q[i], wdata, be);
                if (DBUF) begin
                  pend_d = 1'b1;
                end else begin
                  out_d[i] = be_merge(shadow_q[i], wdata, be);
                  upd_d[i] = 1'b1;
                end
              end
            end
            // Commit bit lives in the lowest byte, so that byte must be enabled.
            if (is_ctrl && be[0] && wdata[0]) begin
              commit_d = commit_q + 16'd1;
              if (DBUF) begin
                out_d  = shadow_q;
                upd_d  = '1;
                pend_d = 1'b0;
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any transfer in flight.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      state_q  <= S_IDLE;
      rdata_q  <= '0;
      shadow_q <= {C_NUM_REGS{C_INIT}};
      out_q    <= {C_NUM_REGS{C_INIT}};
      upd_q    <= '0;
      commit_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      upd_q    <= upd_d;
      commit_q <= commit_d;
      pend_q   <= pend_d;
    end
  end

  assign Sl_xferAck    = (state_q == S_ACK);
  assign Sl_DBus       = rdata_q;
  assign Sl_errAck     = 1'b0;
  assign Sl_retry      = 1'b0;
  assign Sl_toutSup    = 1'b0;
  assign user_data_out = out_q;
  assign user_update   = upd_q;
  assign commit_count  = commit_q;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench: one direct-mode bank (C_INIT=A5A5A5A5) and one
// double-buffered bank (C_INIT=0) sharing the bus, separate selects.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] B = 32'h01001000;
  localparam logic [31:0] I = 32'hA5A5A5A5;

  logic        clk, rst_n;
  logic [31:0] abus, dbus;
  logic [3:0]  be;
  logic        rnw, seq, sel_dir, sel_dbl;

  logic [31:0]  dir_db, dbl_db;
  logic         dir_ack, dbl_ack, dir_err, dbl_err, dir_rty, dbl_rty, dir_to, dbl_to;
  logic [127:0] dir_out, dbl_out;
  logic [3:0]   dir_upd, dbl_upd;
  logic [15:0]  dir_cnt, dbl_cnt;

  int total = 0;
  int bad   = 0;

  opb_register_bank_ppc2simulink #(.C_DOUBLE_BUF(0), .C_INIT(I)) u_dir (
    .OPB_Clk(clk), .OPB_Rst(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel_dir), .OPB_seqAddr(seq),
    .Sl_DBus(dir_db), .Sl_xferAck(dir_ack), .Sl_errAck(dir_err), .Sl_retry(dir_rty),
    .Sl_toutSup(dir_to), .user_data_out(dir_out), .user_update(dir_upd),
    .commit_count(dir_cnt));

  opb_register_bank_ppc2simulink #(.C_DOUBLE_BUF(1), .C_INIT(32'h0)) u_dbl (
    .OPB_Clk(clk), .OPB_Rst(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel_dbl), .OPB_seqAddr(seq),
    .Sl_DBus(dbl_db), .Sl_xferAck(dbl_ack), .Sl_errAck(dbl_err), .Sl_retry(dbl_rty),
    .Sl_toutSup(dbl_to), .user_data_out(dbl_out), .user_update(dbl_upd),
    .commit_count(dbl_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit           rnw;
    logic [31:0]  addr;
    logic [3:0]   be;
    logic [31:0]  data;
    logic [31:0]  exp_rd;
    logic [3:0]   exp_upd;
    logic [127:0] exp_out;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One transfer; returns what was seen during the ack cycle.
  task automatic xfer(input bit which, input bit rnw_v, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d,
                      output logic ack_o, output logic [31:0] rd_o,
                      output logic [3:0] upd_o, output logic [127:0] out_o,
                      output logic [15:0] cnt_o);
    abus = a; be = b; dbus = d; rnw = rnw_v;
    if (which) sel_dbl = 1'b1; else sel_dir = 1'b1;
    @(posedge clk); @(negedge clk);
    ack_o = which ? dbl_ack : dir_ack;
    rd_o  = which ? dbl_db  : dir_db;
    upd_o = which ? dbl_upd : dir_upd;
    out_o = which ? dbl_out : dir_out;
    cnt_o = which ? dbl_cnt : dir_cnt;
    sel_dir = 1'b0; sel_dbl = 1'b0; rnw = 1'b0; dbus = '0; be = '0;
    @(posedge clk); @(negedge clk);
  endtask

  vec_t         vecs[16];
  logic         ack;
  logic [31:0]  rd;
  logic [3:0]   upd;
  logic [127:0] outv;
  logic [15:0]  cnt;
  logic [3:0]   pat;

  initial begin
    rst_n = 1'b0; abus = '0; dbus = '0; be = '0; rnw = 1'b0; seq = 1'b0;
    sel_dir = 1'b0; sel_dbl = 1'b0;

    // ch order in exp_out is {ch3, ch2, ch1, ch0}
    vecs[0]  = '{0, B+4,    4'b1111, 32'h12345678, 32'h0,        4'b0010, {I, I, 32'h12345678, I}};
    vecs[1]  = '{1, B+4,    4'b0000, 32'h0,        32'h12345678, 4'b0000, {I, I, 32'h12345678, I}};
    vecs[2]  = '{0, B+8,    4'b1111, 32'h0,        32'h0,        4'b0100, {I, 32'h0, 32'h12345678, I}};
    vecs[3]  = '{0, B+8,    4'b0100, 32'hFFFFFFFF, 32'h0,        4'b0100, {I, 32'h00FF0000, 32'h12345678, I}};
    vecs[4]  = '{1, B+8,    4'b0000, 32'h0,        32'h00FF0000, 4'b0000, {I, 32'h00FF0000, 32'h12345678, I}};
    vecs[5]  = '{0, B+0,    4'b0000, 32'h0,        32'h0,        4'b0001, {I, 32'h00FF0000, 32'h12345678, I}};
    vecs[6]  = '{0, B+0,    4'b1000, 32'h11223344, 32'h0,        4'b0001, {I, 32'h00FF0000, 32'h12345678, 32'h11A5A5A5}};
    vecs[7]  = '{0, B+12,   4'b0011, 32'hDEADBEEF, 32'h0,        4'b1000, {32'hA5A5BEEF, 32'h00FF0000, 32'h12345678, 32'h11A5A5A5}};
    vecs[8]  = '{1, B+'h80, 4'b0000, 32'h0,        32'h0,        4'b0000, {32'hA5A5BEEF, 32'h00FF0000, 32'h12345678, 32'h11A5A5A5}};
    vecs[9]  = '{0, B+'h80, 4'b1111, 32'hFFFFFFFF, 32'h0,        4'b0000, {32'hA5A5BEEF, 32'h00FF0000, 32'h12345678, 32'h11A5A5A5}};
    vecs[10] = '{1, B+16,   4'b0000, 32'h0,        32'h0,        4'b0000, {32'hA5A5BEEF, 32'h00FF0000, 32'h12345678, 32'h11A5A5A5}};
    vecs[11] = '{0, B+16,   4'b1111, 32'h00000001, 32'h0,        4'b0000, {32'hA5A5BEEF, 32'h00FF0000, 32'h12345678, 32'h11A5A5A5}};
    vecs[12] = '{1, B+16,   4'b0000, 32'h0,        32'h00000001, 4'b0000, {32'hA5A5BEEF, 32'h00FF0000, 32'h12345678, 32'h11A5A5A5}};
    vecs[13] = '{0, B+16,   4'b1111, 32'hFFFFFFFE, 32'h0,        4'b0000, {32'hA5A5BEEF, 32'h00FF0000, 32'h12345678, 32'h11A5A5A5}};
    vecs[14] = '{1, B+16,   4'b0000, 32'h0,        32'h00000001, 4'b0000, {32'hA5A5BEEF, 32'h00FF0000, 32'h12345678, 32'h11A5A5A5}};
    vecs[15] = '{1, B+'hFC, 4'b0000, 32'h0,        32'h0,        4'b0000, {32'hA5A5BEEF, 32'h00FF0000, 32'h12345678, 32'h11A5A5A5}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset dir out",  128'(dir_out), {4{I}});
    chk("reset dbl out",  128'(dbl_out), 128'h0);
    chk("reset ack",      128'(dir_ack), 128'h0);
    chk("reset dbus",     128'(dir_db),  128'h0);
    chk("reset count",    128'(dir_cnt), 128'h0);
    chk("reset upd",      128'(dir_upd), 128'h0);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      xfer(0, vecs[i].rnw, vecs[i].addr, vecs[i].be, vecs[i].data, ack, rd, upd, outv, cnt);
      chk($sformatf("vec%0d ack", i),  128'(ack),  128'h1);
      chk($sformatf("vec%0d rd", i),   128'(rd),   128'(vecs[i].exp_rd));
      chk($sformatf("vec%0d upd", i),  128'(upd),  128'(vecs[i].exp_upd));
      chk($sformatf("vec%0d out", i),  outv,       vecs[i].exp_out);
    end
    chk("dir commit_count", 128'(dir_cnt), 128'h1);
    chk("dir sideband", 128'({dir_err, dir_rty, dir_to}), 128'h0);

    // Double-buffered: shadows fill, outputs hold until commit.
    for (int c = 0; c < 4; c++) begin
      xfer(1, 0, B + 32'(4*c), 4'b1111, 32'h11 * 32'(c+1), ack, rd, upd, outv, cnt);
      chk($sformatf("dbl wr%0d ack", c), 128'(ack),  128'h1);
      chk($sformatf("dbl wr%0d upd", c), 128'(upd),  128'h0);
      chk($sformatf("dbl wr%0d out", c), outv,       128'h0);
    end
    xfer(1, 1, B+16, 4'b0000, 32'h0, ack, rd, upd, outv, cnt);
    chk("dbl ctrl pending", 128'(rd), 128'h00010000);
    xfer(1, 0, B+16, 4'b1111, 32'h1, ack, rd, upd, outv, cnt);
    chk("dbl commit out", outv, {32'h44, 32'h33, 32'h22, 32'h11});
    chk("dbl commit upd", 128'(upd), 128'hF);
    chk("dbl commit cnt", 128'(cnt), 128'h1);
    xfer(1, 1, B+16, 4'b0000, 32'h0, ack, rd, upd, outv, cnt);
    chk("dbl ctrl after commit", 128'(rd), 128'h00000001);
    xfer(1, 1, B+8, 4'b0000, 32'h0, ack, rd, upd, outv, cnt);
    chk("dbl shadow read", 128'(rd), 128'h33);
    xfer(1, 0, B+0, 4'b1111, 32'h55, ack, rd, upd, outv, cnt);
    chk("dbl hold out", outv, {32'h44, 32'h33, 32'h22, 32'h11});
    xfer(1, 1, B+16, 4'b0000, 32'h0, ack, rd, upd, outv, cnt);
    chk("dbl ctrl pend+cnt", 128'(rd), 128'h00010001);

    // Counter wrap: preload the counter just below rollover.
    u_dbl.commit_q = 16'hFFFF;
    xfer(1, 0, B+16, 4'b1111, 32'h1, ack, rd, upd, outv, cnt);
    chk("wrap cnt", 128'(cnt), 128'h0);
    chk("wrap out", outv, {32'h44, 32'h33, 32'h22, 32'h55});
    xfer(1, 1, B+16, 4'b0000, 32'h0, ack, rd, upd, outv, cnt);
    chk("wrap ctrl read", 128'(rd), 128'h0);

    // Select held for 4 cycles: two back-to-back transfers.
    abus = B+4; rnw = 1'b1; sel_dir = 1'b1; pat = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      pat = {pat[2:0], dir_ack};
      if (k == 0) chk("held first rd", 128'(dir_db), 128'h12345678);
    end
    sel_dir = 1'b0; rnw = 1'b0;
    chk("held ack pattern", 128'(pat), 128'hA);
    @(posedge clk); @(negedge clk);

    // Reset during an ack cycle.
    abus = B+4; dbus = 32'h0; be = 4'b1111; rnw = 1'b0; sel_dir = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("pre-reset ack", 128'(dir_ack), 128'h1);
    chk("pre-reset ch1", 128'(dir_out[63:32]), 128'h0);
    rst_n = 1'b0;
    #1;
    chk("rst ack drop", 128'(dir_ack), 128'h0);
    chk("rst out", dir_out, {4{I}});
    chk("rst upd", 128'(dir_upd), 128'h0);
    chk("rst dbl cnt", 128'(dbl_cnt), 128'h0);
    sel_dir = 1'b0; be = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(0, 1, B+4, 4'b0000, 32'h0, ack, rd, upd, outv, cnt);
    chk("post-reset rd", 128'(rd), 128'(I));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
